// File: rtl/v_wb_sequencer.sv
// Vector writeback sequencer: buffers one lane result group, streams it to the VRF.
// Optional V_WB_MASK_EN derives per-register byte enables from v0_mask/vsew.
module v_wb_sequencer #(
    parameter int VLEN = 128,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic            is_mul,
    input  logic [2:0]      lmul,
    input  logic [AW-1:0]   vd,
    input  logic [VLEN-1:0] result_valu_1,
    input  logic [VLEN-1:0] result_valu_2,
    input  logic [VLEN-1:0] result_valu_3,
    input  logic [VLEN-1:0] result_valu_4,
    input  logic [VLEN-1:0] result_vmul_1,
    input  logic [VLEN-1:0] result_vmul_2,
    input  logic [VLEN-1:0] result_vmul_3,
    input  logic [VLEN-1:0] result_vmul_4,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [VLEN-1:0] wr_data,
    output logic [15:0]     wr_be,
    input  logic            wr_ready,
    output logic            busy,
    output logic            wb_done,
    output logic            start_drop
`ifdef V_WB_MASK_EN
    ,
    input  logic [63:0]     v0_mask,
    input  logic [2:0]      vsew
`endif
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      last_q, last_d;
    logic [AW-1:0]   vd_q, vd_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [VLEN-1:0] wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            wb_done_q, wb_done_d;
    logic            start_drop_q, start_drop_d;
    logic [VLEN-1:0] wbuf_q [4];
    logic [VLEN-1:0] wbuf_d [4];
    logic [VLEN-1:0] in_w [4];

    function automatic logic [1:0] grp_last(input logic [2:0] l);
        case (l)
            3'b001:  return 2'd1;
            3'b010:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

`ifdef V_WB_MASK_EN
    logic [63:0] mask_q, mask_d;
    logic [2:0]  sew_q, sew_d;
    logic [15:0] wr_be_q, wr_be_d;

    // Element j of register idx is mask bit (elements-per-reg * idx + j).
    function automatic logic [15:0] mask_be(input logic [63:0] m,
                                            input logic [2:0] sew,
                                            input logic [1:0] idx);
        logic [15:0] be;
        for (int b = 0; b < 16; b++) begin
            case (sew)
                3'd0:    be[b] = m[{idx, 4'(b)}];
                3'd1:    be[b] = m[{1'b0, idx, 3'(b >> 1)}];
                3'd2:    be[b] = m[{2'b00, idx, 2'(b >> 2)}];
                default: be[b] = 1'b1;
            endcase
        end
        return be;
    endfunction

    assign wr_be = wr_be_q;
`else
    assign wr_be = 16'hFFFF;
`endif

    always_comb begin
        in_w[0] = is_mul ? result_vmul_1 : result_valu_1;
        in_w[1] = is_mul ? result_vmul_2 : result_valu_2;
        in_w[2] = is_mul ? result_vmul_3 : result_valu_3;
        in_w[3] = is_mul ? result_vmul_4 : result_valu_4;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_d       = last_q;
        vd_d         = vd_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        wb_done_d    = 1'b0;
        start_drop_d = start_drop_q;
        wbuf_d       = wbuf_q;
`ifdef V_WB_MASK_EN
        mask_d       = mask_q;
        sew_d        = sew_q;
        wr_be_d      = wr_be_q;
`endif
        case (state_q)
            WRITE: begin
                start_drop_d = start_drop_q | start;
                if (wr_ready) begin
                    if (idx_q == last_q) begin
                        state_d   = DONE;
                        wr_en_d   = 1'b0;
                        busy_d    = 1'b0;
                        wb_done_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        wr_addr_d = vd_q + AW'(idx_d);
                        wr_data_d = wbuf_q[idx_d];
`ifdef V_WB_MASK_EN
                        wr_be_d   = mask_be(mask_q, sew_q, idx_d);
`endif
                    end
                end
            end
            default: begin
                // DONE behaves like IDLE so groups can issue back to back.
                state_d = IDLE;
                busy_d  = 1'b0;
                wr_en_d = 1'b0;
                if (start) begin
                    state_d   = WRITE;
                    wbuf_d    = in_w;
                    last_d    = grp_last(lmul);
                    vd_d      = vd;
                    idx_d     = 2'd0;
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = vd;
                    wr_data_d = in_w[0];
`ifdef V_WB_MASK_EN
                    mask_d    = v0_mask;
                    sew_d     = vsew;
                    wr_be_d   = mask_be(v0_mask, vsew, 2'd0);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            wb_done_q    <= 1'b0;
            start_drop_q <= 1'b0;
`ifdef V_WB_MASK_EN
            wr_be_q      <= '1;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            wb_done_q    <= wb_done_d;
            start_drop_q <= start_drop_d;
`ifdef V_WB_MASK_EN
            wr_be_q      <= wr_be_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        wbuf_q <= wbuf_d;
        last_q <= last_d;
        vd_q   <= vd_d;
`ifdef V_WB_MASK_EN
        mask_q <= mask_d;
        sew_q  <= sew_d;
`endif
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign wb_done    = wb_done_q;
    assign start_drop = start_drop_q;

endmodule

// File: doc/v_wb_sequencer.md
Name: v_wb_sequencer

Overview:
- Writeback end of the vector lane datapath.
- Accepts the 4×128-bit ALU/MUL result groups from the lane array when the lanes' done pulse arrives, and selects ALU or MUL results.
- Issues one 128-bit register write per accepted handshake to the vector register file, covering the LMUL register group starting at vd.
- Sits between the lane array and the VRF write port.

Parameters:
- VLEN, 128, bits per vector register and per result word.
- NREG, 32, number of architectural vector registers; address width is log2(NREG).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nrst  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle pulse: lane results valid (lanes' done).
- is_mul  input  1  1 = capture result_vmul_*, 0 = capture result_valu_*.
- lmul  input  3  group size: 3'b000=1 reg, 3'b001=2, 3'b010=4, other=1.
- vd  input  5  destination base register.
- result_valu_1..4  input  VLEN each  ALU result words 1..4.
- result_vmul_1..4  input  VLEN each  MUL result words 1..4.
- wr_en  output  1  VRF write request valid.
- wr_addr  output  5  VRF write address.
- wr_data  output  VLEN  VRF write data.
- wr_be  output  16  byte enables; all ones unless V_WB_MASK_EN.
- wr_ready  input  1  VRF accepts the write when wr_en && wr_ready.
- busy  output  1  sequencer holding an uncommitted group.
- wb_done  output  1  one-cycle pulse after the last write is accepted.
- start_drop  output  1  sticky: a start arrived while busy.
- v0_mask  input  64  element mask (V_WB_MASK_EN only).
- vsew  input  3  0=8b, 1=16b, 2=32b (V_WB_MASK_EN only).

Behaviour:
- Reset (nrst=0 at an edge):
  - State goes to IDLE.
  - wr_en, busy, wb_done, start_drop, idx, wr_addr and wr_data are cleared to 0.
  - wr_be is set to all ones.
  - Any in-flight write is abandoned and the buffer contents are don't-care.
  - Reset takes priority over every other event.
- FSM states: IDLE, WRITE, DONE. All outputs are registered.
- IDLE:
  - On start=1, capture the 4 words selected by is_mul into buf[0..3].
  - Latch cnt = group size from lmul, latch vd, and set idx=0.
  - Go to WRITE; busy=1 and wr_en=1 in the next cycle.
- WRITE:
  - Drive wr_addr = (vd + idx) mod 32, wr_data = buf[idx], wr_be per the optional feature.
  - Without wr_ready, hold all outputs stable (standard valid/ready: no retraction, no data change).
  - On wr_en && wr_ready with idx < cnt-1: idx++, next word presented the next cycle.
  - On wr_en && wr_ready with idx == cnt-1: go to DONE, wr_en=0.
- DONE:
  - Lasts 1 cycle: wb_done=1, busy=0, then go to IDLE.
  - A start in this cycle is accepted exactly as in IDLE, so back-to-back groups are possible.
- Latency with wr_ready tied high:
  - start at edge 0; writes occupy cycles 1..cnt; wb_done in cycle cnt+1.
- start while in WRITE: ignored; buffer unchanged; start_drop set to 1 and held until reset.
- Address wrap: vd=31 with lmul=2 writes 31, 0, 1, 2. No alignment check.
- Unused buffer words (idx ≥ cnt) are never written.
- start and wr_ready are not qualified in IDLE; wr_ready is don't-care outside WRITE.

Optional Feature:
- V_WB_MASK_EN defined:
  - v0_mask and vsew ports exist.
  - wr_be for register idx is derived from v0_mask with 16/8/4 elements per register:
    - SEW8: byte b enabled by mask[16*idx+b].
    - SEW16: bytes 2j, 2j+1 enabled by mask[8*idx+j].
    - SEW32: bytes 4j..4j+3 enabled by mask[4*idx+j].
    - vsew ≥ 3 (reserved): all ones.
  - v0_mask and vsew are captured on start.
- V_WB_MASK_EN undefined: the ports are absent and wr_be is constant 16'hFFFF.

Test Plan:
- Reset: nrst=0 for 2 cycles mid-WRITE → next cycle wr_en=0, busy=0, start_drop=0, wr_be=16'hFFFF.
- Single register, no stall:
  - Stimulus: lmul=0, vd=5, is_mul=0, result_valu_1=128'hA5..A5, wr_ready=1, start pulse.
  - Response: one write addr 5 data A5..A5 in cycle 1; wb_done in cycle 2.
- MUL group with stall and wrap:
  - Stimulus: lmul=2, vd=30, is_mul=1, wr_ready low on the 2nd presented write for 3 cycles.
  - Response: addresses 30, 31, 0, 1 with result_vmul_1..4 in order; data/address stable during the stall; wb_done 1 cycle after the 4th accept.
- Dropped start: start during WRITE of a 2-reg group → original data written unchanged, start_drop=1 until reset.
- Back-to-back: start asserted in the wb_done cycle → new group captured; wr_en high the following cycle.
- Mask (V_WB_MASK_EN), SEW32:
  - Stimulus: lmul=1, v0_mask=64'h0000_0000_0000_0095, start.
  - Response: reg0 wr_be=16'h0F0F (mask nibble 0x5 → elements 0, 2); reg1 wr_be=16'hF00F (mask nibble 0x9 → elements 0, 3).
